// File: rtl/mem_seq_arbiter_pkg.sv
// Shared types and constants for the memory sequencer/arbiter: bus widths,
// FSM state encoding and the default bus-timeout length.
package mem_seq_arbiter_pkg;

    localparam int          RegBus        = 32;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    localparam int          TO_CYCLES_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IFETCH  = 3'd1,
        ST_DECODE  = 3'd2,
        ST_DACCESS = 3'd3,
        ST_COMMIT  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_seq_arbiter_if.sv
// External memory bus shared by fetch and load/store. A transfer is open while
// bus_req_o is high and completes on the first cycle bus_ack_i is seen with it.
interface mem_seq_arbiter_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        input  bus_data_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        output bus_data_i, bus_ack_i
    );

endinterface

// File: rtl/mem_seq_timer.sv
// Bus-timeout counter: counts consecutive requesting cycles without ack and
// flags expiry on the TO_CYCLES-th such cycle so the sequencer can abort.
module mem_seq_timer #(
    parameter int TO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ack_i,
    output logic expire_o
);

    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        expire_o = req_i && !ack_i && (cnt_q == CW'(TO_CYCLES - 1));
        cnt_d    = cnt_q + CW'(1);
        // Any gap in the request, an ack, or our own abort starts the count over.
        if (!req_i || ack_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_seq_arbiter.sv
// Serialises each instruction into fetch, optional data access and commit on a
// single shared bus. Define MEM_SEQ_TIMEOUT_EN to abort stuck transfers.
module mem_seq_arbiter
    import mem_seq_arbiter_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_ce_i,
    input  logic [RegBus-1:0]     if_addr_i,
    output logic [RegBus-1:0]     inst_o,
    input  logic                  dm_ce_i,
    input  logic                  dm_we_i,
    input  logic [3:0]            dm_sel_i,
    input  logic [RegBus-1:0]     dm_addr_i,
    input  logic [RegBus-1:0]     dm_data_i,
    output logic [RegBus-1:0]     dm_data_o,
    output logic                  stall_o,
    output logic                  commit_o,
    output logic                  err_o,
    output state_e                state_dbg_o,
    mem_seq_arbiter_if.master     bus
);

    state_e            state_q, state_d;
    logic [RegBus-1:0] inst_q, inst_d;
    logic [RegBus-1:0] dat_q, dat_d;
    logic              err_q, err_d;
    logic              abort;

`ifdef MEM_SEQ_TIMEOUT_EN
    mem_seq_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .req_i    (bus.bus_req_o),
        .ack_i    (bus.bus_ack_i),
        .expire_o (abort)
    );
`else
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES == 0);
    assign abort            = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        inst_d         = inst_q;
        dat_d          = dat_q;
        err_d          = err_q | abort;
        stall_o        = 1'b1;
        commit_o       = 1'b0;
        bus.bus_req_o  = 1'b0;
        bus.bus_we_o   = 1'b0;
        bus.bus_sel_o  = 4'b0000;
        bus.bus_addr_o = ZeroWord;
        bus.bus_data_o = ZeroWord;

        case (state_q)
            ST_IDLE: begin
                if (if_ce_i) state_d = ST_IFETCH;
            end
            ST_IFETCH: begin
                bus.bus_req_o  = 1'b1;
                bus.bus_sel_o  = 4'b1111;
                bus.bus_addr_o = if_addr_i;
                if (bus.bus_ack_i) begin
                    inst_d  = bus.bus_data_i;
                    state_d = ST_DECODE;
                end else if (abort) begin
                    inst_d  = ZeroWord;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = dm_ce_i ? ST_DACCESS : ST_COMMIT;
            end
            ST_DACCESS: begin
                bus.bus_req_o  = 1'b1;
                bus.bus_we_o   = dm_we_i;
                bus.bus_sel_o  = dm_sel_i;
                bus.bus_addr_o = dm_addr_i;
                bus.bus_data_o = dm_data_i;
                // An aborted load still retires, returning zero as its data.
                if (bus.bus_ack_i || abort) begin
                    if (!dm_we_i) dat_d = bus.bus_ack_i ? bus.bus_data_i : ZeroWord;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                stall_o  = 1'b0;
                commit_o = 1'b1;
                state_d  = if_ce_i ? ST_IFETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            inst_q  <= ZeroWord;
            dat_q   <= ZeroWord;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

    assign inst_o      = inst_q;
    assign dm_data_o   = dat_q;
    assign err_o       = err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_mem_seq_arbiter.sv
// Directed and randomised instruction sequences against mem_seq_arbiter, with a
// scoreboard of expected instruction/load data checked at each commit.
module tb_mem_seq_arbiter;
    import mem_seq_arbiter_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] inst_o;
    logic        dm_ce_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_i;
    logic [31:0] dm_data_o;
    logic        stall_o;
    logic        commit_o;
    logic        err_o;
    state_e      state_dbg;

    mem_seq_arbiter_if bus_if ();

    mem_seq_arbiter #(.TO_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_ce_i     (if_ce_i),
        .if_addr_i   (if_addr_i),
        .inst_o      (inst_o),
        .dm_ce_i     (dm_ce_i),
        .dm_we_i     (dm_we_i),
        .dm_sel_i    (dm_sel_i),
        .dm_addr_i   (dm_addr_i),
        .dm_data_i   (dm_data_i),
        .dm_data_o   (dm_data_o),
        .stall_o     (stall_o),
        .commit_o    (commit_o),
        .err_o       (err_o),
        .state_dbg_o (state_dbg),
        .bus         (bus_if)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_dat = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Plays core + memory for one instruction, from the cycle before its fetch
    // through its commit. fw/dw are ack wait cycles; a negative value never acks.
    task automatic run_instr(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                             input logic mem, input logic we, input logic [3:0] sel,
                             input logic [31:0] daddr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int fw, input int dw,
                             input int exp_cyc);
        logic [31:0] exp_inst;
        int          cyc = 0, fcnt = 0, dcnt = 0, budget = 0, phase = 0;
        bit          done = 0;
        exp_inst = (fw < 0) ? 32'h0 : inst;
        if (mem && !we) exp_dat = (dw < 0) ? 32'h0 : rdata;
        exp_q.push_back(exp_inst);
        exp_q.push_back(exp_dat);
        if_ce_i = 1'b1; if_addr_i = pc; dm_ce_i = mem; dm_we_i = we;
        dm_sel_i = sel; dm_addr_i = daddr; dm_data_i = wdata;
        while (!done && budget < 200) begin
            @(negedge clk);
            budget++;
            bus_if.bus_ack_i  = 1'b0;
            bus_if.bus_data_i = $urandom;
            #1;
            if (bus_if.bus_req_o) phase = (phase == 0) ? 1 : phase;
            if (phase != 0) cyc++;
            if (commit_o) begin
                chk({tag, " inst_at_commit"}, inst_o, exp_q.pop_front());
                chk({tag, " dat_at_commit"}, dm_data_o, exp_q.pop_front());
                chk({tag, " cycles"}, cyc, exp_cyc);
                chk({tag, " stall_at_commit"}, {31'b0, stall_o}, 32'd0);
                done = 1;
            end else if (bus_if.bus_req_o && phase == 1) begin
                chk({tag, " fetch_ctl"}, {27'b0, bus_if.bus_we_o, bus_if.bus_sel_o}, 32'h0000_000F);
                chk({tag, " fetch_addr"}, bus_if.bus_addr_o, pc);
                if (fw >= 0 && fcnt == fw) begin
                    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = inst;
                end
                fcnt++;
            end else if (bus_if.bus_req_o) begin
                chk({tag, " data_ctl"}, {27'b0, bus_if.bus_we_o, bus_if.bus_sel_o}, {27'b0, we, sel});
                chk({tag, " data_addr"}, bus_if.bus_addr_o, daddr);
                chk({tag, " data_wdata"}, bus_if.bus_data_o, wdata);
                if (dw >= 0 && dcnt == dw) begin
                    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = rdata;
                end
                dcnt++;
            end else begin
                chk({tag, " idle_bus_addr"}, bus_if.bus_addr_o | bus_if.bus_data_o, 32'h0);
                chk({tag, " idle_bus_ctl"}, {27'b0, bus_if.bus_we_o, bus_if.bus_sel_o}, 32'h0);
                chk({tag, " stall"}, {31'b0, stall_o}, 32'd1);
                if (phase == 1) begin
                    phase = 2;
                    chk({tag, " inst_in_decode"}, inst_o, exp_inst);
                end
                // Stray acks while nothing is requested must be ignored.
                bus_if.bus_ack_i = 1'($urandom_range(0, 1));
            end
        end
        chk({tag, " commit_reached"}, {31'b0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; if_ce_i = 1'b0; if_addr_i = 32'h0; dm_ce_i = 1'b0; dm_we_i = 1'b0;
        dm_sel_i = 4'h0; dm_addr_i = 32'h0; dm_data_i = 32'h0;
        bus_if.bus_ack_i = 1'b0; bus_if.bus_data_i = 32'h0;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst inst_o", inst_o, 32'h0);
        chk("rst dm_data_o", dm_data_o, 32'h0);
        chk("rst req", {31'b0, bus_if.bus_req_o}, 32'd0);
        chk("rst stall/commit/err", {29'b0, stall_o, commit_o, err_o}, 32'b100);
        chk("rst state", 32'(state_dbg), 32'(ST_IDLE));

        // release with fetch enabled, then reset again mid-IFETCH
        @(negedge clk);
        rst = 1'b1; if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
        #1;
        chk("idle req", {31'b0, bus_if.bus_req_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("ifetch req", {31'b0, bus_if.bus_req_o}, 32'd1);
        chk("ifetch addr", bus_if.bus_addr_o, 32'h0000_0100);
        rst = 1'b0;
        #1;
        chk("midrst req", {31'b0, bus_if.bus_req_o}, 32'd0);
        chk("midrst addr", bus_if.bus_addr_o, 32'h0);
        chk("midrst stall/commit", {30'b0, stall_o, commit_o}, 32'b10);
        @(negedge clk);
        rst = 1'b1;

        run_instr("alu", 32'h0000_0100, 32'h3401_0020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 3);
        run_instr("load", 32'h0000_0104, 32'h8C01_0040, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0,
                  32'hDEAD_BEEF, 0, 2, 6);
        run_instr("store", 32'h0000_0108, 32'hAC01_0010, 1'b1, 1'b1, 4'b0011, 32'h0000_0010,
                  32'h0000_1234, 32'hBAD0_BAD0, 0, 0, 4);

        // fetch disabled at commit: stay idle until it returns
        if_ce_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("parked req", {31'b0, bus_if.bus_req_o}, 32'd0);
            chk("parked state", 32'(state_dbg), 32'(ST_IDLE));
        end
        run_instr("fetch_wait", 32'h0000_010C, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 3, 0, 6);

        for (int i = 0; i < 8; i++) begin
            int          fw, dw;
            logic        mem, we;
            fw  = $urandom_range(0, 2);
            dw  = $urandom_range(0, 2);
            mem = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            run_instr("rand", 32'h0000_0200 + 32'(i * 4), $urandom, mem, we, 4'($urandom_range(1, 15)),
                      $urandom, $urandom, $urandom, fw, dw, mem ? (4 + fw + dw) : (3 + fw));
        end

`ifdef MEM_SEQ_TIMEOUT_EN
        run_instr("to_fetch", 32'h0000_0300, 32'h1234_5678, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                  -1, 0, 3 + TO - 1);
        chk("err after fetch timeout", {31'b0, err_o}, 32'd1);
        run_instr("to_load", 32'h0000_0304, 32'h8C02_0080, 1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h0,
                  32'hFFFF_FFFF, 0, -1, 4 + TO - 1);
        run_instr("after_to", 32'h0000_0308, 32'h3402_0001, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 0, 4);
        chk("err sticky", {31'b0, err_o}, 32'd1);
`else
        chk("err tied low", {31'b0, err_o}, 32'd0);
`endif

        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
